// File: rtl/branch_fetch_if.sv
// Fetch-control bus: pipeline-side hazard inputs and fetch-side PC/status outputs.
// master = pipeline/driver side, slave = branch_fetch_ctrl.
interface branch_fetch_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    // Handshake: resolve_valid is a single-cycle pulse with no back-pressure;
    // resolve_taken/resolve_target are qualified by it. fetch_valid qualifies pc.
    logic              stall;
    logic              is_branch_id;
    logic              resolve_valid;
    logic              resolve_taken;
    logic [ADDR_W-1:0] resolve_target;
    logic [ADDR_W-1:0] pc;
    logic              fetch_valid;
    logic              bubble;
    logic              redirect;
    logic              timeout_err;
    logic [CNT_W-1:0]  branch_cnt;
    logic [CNT_W-1:0]  taken_cnt;
    logic [1:0]        state_dbg;

    modport master (
        output stall, is_branch_id, resolve_valid, resolve_taken, resolve_target,
        input  pc, fetch_valid, bubble, redirect, timeout_err, branch_cnt, taken_cnt,
        input  state_dbg
    );

    modport slave (
        input  stall, is_branch_id, resolve_valid, resolve_taken, resolve_target,
        output pc, fetch_valid, bubble, redirect, timeout_err, branch_cnt, taken_cnt,
        output state_dbg
    );
endinterface

// File: rtl/branch_fetch_ctrl.sv
// Fetch PC owner: freezes fetch on a decoded branch, bubbles until resolution,
// then redirects or falls through. Keeps saturating branch/taken counters.
module branch_fetch_ctrl #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                MAX_WAIT = 4,
    parameter int                CNT_W    = 16
) (
    input  logic           clk,
    input  logic           rst,
    branch_fetch_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_WAIT  = 2'b01,
        ST_REDIR = 2'b10,
        ST_BAD   = 2'b11
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [3:0]        wait_q, wait_d;
    logic              redirect_q, redirect_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  bcnt_q, bcnt_d;
    logic [CNT_W-1:0]  tcnt_q, tcnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            wait_q     <= '0;
            redirect_q <= 1'b0;
            timeout_q  <= 1'b0;
            bcnt_q     <= '0;
            tcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            wait_q     <= wait_d;
            redirect_q <= redirect_d;
            timeout_q  <= timeout_d;
            bcnt_q     <= bcnt_d;
            tcnt_q     <= tcnt_d;
        end
    end

    always_comb begin
        state_d    = ST_RUN;
        pc_d       = pc_q;
        wait_d     = wait_q;
        redirect_d = 1'b0;
        timeout_d  = timeout_q;
        bcnt_d     = bcnt_q;
        tcnt_d     = tcnt_q;

        case (state_q)
            ST_RUN: begin
                // A decoded branch wins over stall; pc stays on the fall-through.
                if (bus.is_branch_id) begin
                    state_d = ST_WAIT;
                    wait_d  = '0;
                    if (bcnt_q != '1) begin
                        bcnt_d = bcnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = ST_RUN;
                    if (!bus.stall) begin
                        pc_d = pc_q + ADDR_W'(4);
                    end
                end
            end

            ST_WAIT: begin
                if (bus.resolve_valid) begin
                    if (bus.resolve_taken) begin
                        state_d    = ST_REDIR;
                        pc_d       = bus.resolve_target & ~ADDR_W'(3);
                        redirect_d = 1'b1;
                        if (tcnt_q != '1) begin
                            tcnt_d = tcnt_q + CNT_W'(1);
                        end
                    end else begin
                        state_d = ST_RUN;
                    end
                end else if (!bus.stall) begin
                    if (wait_q == WAIT_LAST) begin
                        state_d   = ST_RUN;
                        timeout_d = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        wait_d  = wait_q + 4'd1;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end

            ST_REDIR: begin
                state_d = ST_RUN;
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign bus.pc          = pc_q;
    assign bus.fetch_valid = (state_q == ST_RUN) & ~bus.stall & ~bus.is_branch_id;
    assign bus.bubble      = (state_q == ST_WAIT) | (state_q == ST_REDIR);
    assign bus.redirect    = redirect_q;
    assign bus.timeout_err = timeout_q;
    assign bus.branch_cnt  = bcnt_q;
    assign bus.taken_cnt   = tcnt_q;
    assign bus.state_dbg   = state_q;
endmodule
